// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM sequencer.
// Optional dead-time build is selected with PWM_DEADTIME_EN.
package pwm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;

    localparam int PWM_CNT_W = 8;
    localparam int PWM_DEAD  = 2;
endpackage

// File: rtl/pwm_ctrl_if.sv
// Config/status bundle between the requester and pwm_ctrl.
// pwm_out_n exists only when PWM_DEADTIME_EN is defined.
interface pwm_ctrl_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) ();
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic             load;
    logic             load_ack;
    logic             pwm_out;
    logic             cycle_end;
    logic             busy;
`ifdef PWM_DEADTIME_EN
    logic             pwm_out_n;

    modport master (output en, period, duty, load,
                    input  load_ack, pwm_out, pwm_out_n, cycle_end, busy);
    modport slave  (input  en, period, duty, load,
                    output load_ack, pwm_out, pwm_out_n, cycle_end, busy);
`else
    modport master (output en, period, duty, load,
                    input  load_ack, pwm_out, cycle_end, busy);
    modport slave  (input  en, period, duty, load,
                    output load_ack, pwm_out, cycle_end, busy);
`endif
endinterface

// File: rtl/pwm_deadband.sv
// Dead-time inserter: each edge of cmp holds both channels low for DEAD cycles.
// Latency: one registered stage; no backpressure. Pulses shorter than DEAD never reach the outputs.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DEAD = PWM_DEAD
) (
    input  logic ck,
    input  logic rst_n,
    input  logic active,
    input  logic cmp,
    output logic out_p,
    output logic out_n
);
    localparam int DW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);

    logic          lvl;
    logic [DW-1:0] dcnt;

    always_ff @(posedge ck) begin
        if (!rst_n || !active) begin
            lvl   <= 1'b0;
            dcnt  <= '0;
            out_p <= 1'b0;
            out_n <= 1'b0;
        end else if (cmp != lvl) begin
            // A new edge restarts the gap, so a short pulse is swallowed whole.
            lvl   <= cmp;
            dcnt  <= DW'(DEAD - 1);
            out_p <= 1'b0;
            out_n <= 1'b0;
        end else if (dcnt != '0) begin
            dcnt  <= dcnt - DW'(1);
            out_p <= 1'b0;
            out_n <= 1'b0;
        end else begin
            out_p <= lvl;
            out_n <= ~lvl;
        end
    end
endmodule

// File: rtl/pwm_ctrl.sv
// PWM sequencer: period counter, duty compare, glitch-free staged updates (option: PWM_DEADTIME_EN).
// Latency: pwm_out/cycle_end one cycle after the counter; load_ack one cycle after capture.
// Backpressure: a load waits un-acked while staging is occupied; the requester holds it stable.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
`ifdef PWM_DEADTIME_EN
    , parameter int DEAD = PWM_DEAD
`endif
) (
    input  logic ck,
    input  logic rst_n,
    pwm_ctrl_if.slave bus
);
    pwm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_duty;
    logic [CNT_W-1:0] stg_period;
    logic [CNT_W-1:0] stg_duty;
    logic             pending;
    logic             cmp_q;
    logic             load_ack_q;
    logic             cycle_end_q;
    logic             busy_q;

    logic running;
    logic term;
    logic commit;
    logic capture;

    assign running = (state != IDLE);
    assign term    = running && (cnt == act_period);
    // Capture needs staging already free; capture and commit never coincide.
    assign commit  = pending && (!running || term);
    assign capture = bus.load && !pending;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            act_period  <= '0;
            act_duty    <= '0;
            stg_period  <= '0;
            stg_duty    <= '0;
            pending     <= 1'b0;
            cmp_q       <= 1'b0;
            load_ack_q  <= 1'b0;
            cycle_end_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            load_ack_q  <= capture;
            cycle_end_q <= term;
            cmp_q       <= running && (cnt < act_duty);
            pending     <= capture || (pending && !commit);
            if (capture) begin
                stg_period <= bus.period;
                stg_duty   <= bus.duty;
            end
            if (commit) begin
                act_period <= stg_period;
                act_duty   <= stg_duty;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.en) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RUN, STOP: begin
                    cnt <= term ? '0 : cnt + CNT_W'(1);
                    if (bus.en) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else if (term) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= STOP;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ack  = load_ack_q;
    assign bus.cycle_end = cycle_end_q;
    assign bus.busy      = busy_q;

`ifdef PWM_DEADTIME_EN
    logic run_q;

    always_ff @(posedge ck) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= running;
    end

    pwm_deadband #(.DEAD(DEAD)) u_deadband (
        .ck     (ck),
        .rst_n  (rst_n),
        .active (run_q),
        .cmp    (cmp_q),
        .out_p  (bus.pwm_out),
        .out_n  (bus.pwm_out_n)
    );
`else
    assign bus.pwm_out = cmp_q;
`endif
endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: directed scenarios plus random en/load traffic against a period-level model.
module tb_pwm_ctrl;
    import pwm_pkg::*;

    logic ck;
    logic rst_n;

    pwm_ctrl_if #(.CNT_W(8)) bus ();

    pwm_ctrl #(.CNT_W(8)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    typedef struct {
        int p;
        int d;
    } cfg_t;

    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference: position inside the current period and the settings in force.
    bit   m_active = 1'b0;
    int   m_pos    = 0;
    int   m_per    = 0;
    int   m_dut    = 0;
    cfg_t stg[$];
    bit   e_pwm = 1'b0, e_ack = 1'b0, e_cend = 1'b0, e_busy = 1'b0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        bit   i_rst, i_en, i_load, last;
        cfg_t c;
        i_rst  = rst_n;
        i_en   = bus.en;
        i_load = bus.load;
        c.p    = int'(bus.period);
        c.d    = int'(bus.duty);
        @(posedge ck);
        if (!i_rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_per    = 0;
            m_dut    = 0;
            stg.delete();
            e_pwm = 1'b0; e_ack = 1'b0; e_cend = 1'b0; e_busy = 1'b0;
        end else begin
            last   = m_active && (m_pos == m_per);
            e_pwm  = m_active && (m_pos < m_dut);
            e_cend = last;
            e_ack  = i_load && (stg.size() == 0);
            if (stg.size() != 0 && (!m_active || last)) begin
                m_per = stg[0].p;
                m_dut = stg[0].d;
                void'(stg.pop_front());
            end
            if (e_ack) stg.push_back(c);
            if (!m_active) begin
                m_active = i_en;
                m_pos    = 0;
            end else begin
                m_pos    = last ? 0 : m_pos + 1;
                m_active = i_en || !last;
            end
            e_busy = m_active;
        end
        #1;
        chk("pwm_out",   bus.pwm_out,   e_pwm);
        chk("load_ack",  bus.load_ack,  e_ack);
        chk("cycle_end", bus.cycle_end, e_cend);
        chk("busy",      bus.busy,      e_busy);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int p, input int d);
        bit got;
        got        = 1'b0;
        bus.load   = 1'b1;
        bus.period = 8'(p);
        bus.duty   = 8'(d);
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            got = e_ack;
        end
        bus.load = 1'b0;
        if (!got) chk("ack_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_pos(input int n);
        bit hit;
        hit = m_active && (m_pos == n);
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            hit = m_active && (m_pos == n);
        end
        if (!hit) chk("pos_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog at %0t: got no end expected end", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
        bus.period = '0; bus.duty = '0;
        #1;
        run(2);
        rst_n = 1'b1;
        run(2);

        // 3 high / 7 low, period 10
        do_load(9, 3);
        run(2);
        bus.en = 1'b1;
        run(35);

        // mid-period update takes effect at the next wrap
        wait_pos(2);
        do_load(4, 1);
        run(15);

        // second request while the first is still staged
        wait_pos(1);
        do_load(6, 2);
        do_load(3, 3);
        run(20);

        // edge values
        do_load(9, 0);
        run(25);
        do_load(9, 12);
        run(25);
        do_load(0, 1);
        run(8);

        // drop en mid-period, then drop and reassert
        do_load(9, 3);
        run(12);
        wait_pos(3);
        bus.en = 1'b0;
        run(15);
        bus.en = 1'b1;
        run(3);
        wait_pos(3);
        bus.en = 1'b0;
        wait_pos(6);
        bus.en = 1'b1;
        run(25);

        // reset mid-run with staging occupied
        wait_pos(1);
        do_load(5, 2);
        wait_pos(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.en = 1'b0;
        run(2);
        do_load(7, 4);
        run(3);

        // random traffic
        bus.en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) bus.en = ~bus.en;
            if (!bus.load && $urandom_range(9) == 0) begin
                bus.load   = 1'b1;
                bus.period = 8'($urandom_range(12));
                bus.duty   = 8'($urandom_range(14));
            end
            tick();
            if (e_ack) bus.load = 1'b0;
        end
        bus.load = 1'b0;
        bus.en   = 1'b0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
